// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered N:1 round-robin arbitrating mux with valid/ready handshakes.
// The optional RR_ARB_MUX_LOCK_EN macro adds in_last/out_last and packet locking.
// With the macro undefined, every beat is arbitrated on its own.
module rr_arb_mux #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 4,
  localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [N-1:0]       in_last,
  output logic               out_last,
`endif
  output logic [SELW-1:0]    out_sel
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_sel_q;
  logic [SELW-1:0]  ptr_q;
  logic             load;
  logic             gnt_found;
  logic [SELW-1:0]  gnt_idx;
  logic [SELW-1:0]  ptr_nxt;
  logic [WIDTH-1:0] sel_data;
`ifdef RR_ARB_MUX_LOCK_EN
  logic             lock_q;
  logic             out_last_q;
`endif

  // The output register may take a new beat when empty or being drained.
  assign load = !out_valid_q || out_ready;

  // Round-robin search starting at ptr; a locked packet pins the grant.
  always_comb begin
    int unsigned idx;
    logic [SELW-1:0] idx_sel;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    idx_sel   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      idx_sel = idx[SELW-1:0];
      if (!gnt_found && in_valid[idx_sel]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_sel;
      end
    end
`ifdef RR_ARB_MUX_LOCK_EN
    if (lock_q) begin
      gnt_found = in_valid[out_sel_q];
      gnt_idx   = out_sel_q;
    end
`endif
  end

  // Data mux for the granted channel.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(gnt_idx) == i) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Pointer moves to the channel after the winner, wrapping at N-1.
  assign ptr_nxt = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;

  // One-hot accept towards the granted channel; silent while in reset.
  always_comb begin
    in_ready = '0;
    if (rst_n && load && gnt_found) in_ready[gnt_idx] = 1'b1;
  end

  // Output register, selection index and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
      lock_q      <= 1'b0;
      out_last_q  <= 1'b0;
`endif
    end else if (load) begin
      out_valid_q <= gnt_found;
      if (gnt_found) begin
        out_data_q <= sel_data;
        out_sel_q  <= gnt_idx;
`ifdef RR_ARB_MUX_LOCK_EN
        out_last_q <= in_last[gnt_idx];
        if (in_last[gnt_idx]) begin
          lock_q <= 1'b0;
          ptr_q  <= ptr_nxt;
        end else begin
          lock_q <= 1'b1;
        end
`else
        ptr_q      <= ptr_nxt;
`endif
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
`ifdef RR_ARB_MUX_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux (N=4, WIDTH=64); honours RR_ARB_MUX_LOCK_EN.
module tb_rr_arb_mux;
  localparam int W = 64;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [1:0]     out_sel;
  logic [N-1:0]   in_last = '0;
`ifdef RR_ARB_MUX_LOCK_EN
  logic           out_last;
`endif

  int checks = 0;
  int errors = 0;

  rr_arb_mux #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: registered beat plus pointer/lock as plain integers.
  bit         m_valid = 0;
  logic [63:0] m_data = '0;
  int         m_sel = 0;
  int         m_ptr = 0;
  bit         m_lock = 0;
  bit         m_last = 0;
  int         mg;

  function automatic int model_grant();
    if (m_lock) return in_valid[m_sel] ? m_sel : -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_data <= '0; m_sel <= 0; m_ptr <= 0; m_lock <= 0; m_last <= 0;
    end else if (!m_valid || out_ready) begin
      mg = model_grant();
      if (mg < 0) m_valid <= 0;
      else begin
        m_valid <= 1;
        m_data  <= in_data[mg*W +: W];
        m_sel   <= mg;
`ifdef RR_ARB_MUX_LOCK_EN
        m_last <= in_last[mg];
        if (in_last[mg]) begin
          m_lock <= 0;
          m_ptr  <= (mg + 1) % N;
        end else m_lock <= 1;
`else
        m_ptr <= (mg + 1) % N;
`endif
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    int g2;
    if (!rst_n) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_sel", 64'(out_sel), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
    end else begin
      exp_ready = '0;
      g2 = model_grant();
      if ((!m_valid || out_ready) && g2 >= 0) exp_ready[g2] = 1'b1;
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_data", out_data, m_data);
      chk("out_sel", 64'(out_sel), 64'(m_sel));
`ifdef RR_ARB_MUX_LOCK_EN
      chk("out_last", 64'(out_last), 64'(m_last));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [63:0] d);
    in_data[i*W +: W] = d;
  endtask

  initial begin
    logic [N-1:0] pat [8];
    int exp_sel [4];
    pat = '{4'hF, 4'h0, 4'h5, 4'hA, 4'h8, 4'h3, 4'hE, 4'h1};
`ifdef RR_ARB_MUX_LOCK_EN
    exp_sel = '{1, 1, 1, 2};
`else
    exp_sel = '{1, 2, 0, 1};
`endif
    for (int i = 0; i < N; i++) set_ch(i, 64'hC0DE_0000_0000_0000 | 64'(i));
    in_last = 4'hF;

    // 1: reset with all channels requesting.
    #2 rst_n = 1'b0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    tick(); tick();
    chk("t1_in_ready", 64'(in_ready), 64'd0);
    chk("t1_out_valid", 64'(out_valid), 64'd0);
    #2 rst_n = 1'b1;

    // 2: rotating grants 0,1,2,3,0.
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("t2_sel", 64'(out_sel), 64'(j % 4));
      chk("t2_data", out_data, 64'hC0DE_0000_0000_0000 | 64'(j % 4));
    end

    // 3: ch2 alone, then stalled consumer.
    in_valid = 4'b0100;
    set_ch(2, 64'hDEAD_BEEF_CAFE_1234);
    tick();
    chk("t3_sel", 64'(out_sel), 64'd2);
    out_ready = 1'b0;
    set_ch(2, 64'h1111_2222_3333_4444);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_data", out_data, 64'hDEAD_BEEF_CAFE_1234);
      chk("t3_hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("t3_reload_data", out_data, 64'h1111_2222_3333_4444);
    chk("t3_reload_valid", 64'(out_valid), 64'd1);

    // 4: pointer at 3, wrap to ch0 then ch1.
    set_ch(2, 64'hC0DE_0000_0000_0002);
    in_valid = 4'b0011;
    tick();
    chk("t4_wrap_sel", 64'(out_sel), 64'd0);
    tick();
    chk("t4_next_sel", 64'(out_sel), 64'd1);
    in_valid = 4'b0000;
    tick();
    chk("t4_idle_valid", 64'(out_valid), 64'd0);
    chk("t4_idle_data", out_data, 64'hC0DE_0000_0000_0001);

    // 5: asynchronous reset with a beat held.
    in_valid = 4'hF;
    tick();
    chk("t5_loaded", out_data, 64'hC0DE_0000_0000_0002);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 64'(out_valid), 64'd0);
    chk("t5_async_data", out_data, 64'd0);
    in_valid = 4'b1001;
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("t5_ptr_zero", 64'(out_sel), 64'd0);

    // 6: ch1 three-beat packet alongside ch0/ch2.
    in_valid = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      in_last = (k == 2) ? 4'b0010 : 4'b0000;
      tick();
      chk("t6_sel", 64'(out_sel), 64'(exp_sel[k]));
    end

    // Mixed traffic with a throttled consumer, model-checked every cycle.
    for (int i = 0; i < 24; i++) begin
      in_valid  = pat[i % 8];
      out_ready = (i % 3) != 2;
      in_last   = (i % 2 == 1) ? 4'hF : 4'h0;
      for (int c = 0; c < N; c++) set_ch(c, 64'(i * 16 + c));
      tick();
    end
    in_last  = 4'hF;
    in_valid = '0;
    out_ready = 1'b1;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
